// File: rtl/mem_stage_pkg.sv
// ------------------------------------------------------------------
// mem_stage_pkg : shared pipeline bus layouts for the MEM stage
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_stage_pkg;

  localparam int ES_BUS_W  = 180;
  localparam int MS_BUS_W  = 172;
  localparam int FWD_BUS_W = 40;

  // load_op one-hot bit positions: {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_B  = 4;
  localparam int LD_BU = 3;
  localparam int LD_H  = 2;
  localparam int LD_HU = 1;
  localparam int LD_W  = 0;

  // exception_op bit positions: {adef, break, ine, ale}
  localparam int EXC_ADEF = 3;
  localparam int EXC_BRK  = 2;
  localparam int EXC_INE  = 1;
  localparam int EXC_ALE  = 0;

  typedef struct packed {
    logic        ertn;
    logic        we;
    logic        re;
    logic [13:0] num;
    logic [16:0] rsvd;
  } csr_data_t;

  typedef struct packed {
    logic        req_issued;
    logic [4:0]  load_op;
    logic [1:0]  addr_low;
    logic [3:0]  exception_op;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    csr_data_t   csr_data;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  typedef struct packed {
    logic [3:0]  exception_op;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    csr_data_t   csr_data;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_bus_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_load_extend.sv
// ------------------------------------------------------------------
// mem_stage_load_extend : byte/halfword/word select and extension
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [4:0]  load_op,
  input  logic [1:0]  addr_low,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_low)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];

    result = rdata;
    if (load_op[LD_B])       result = {{24{byte_sel[7]}}, byte_sel};
    else if (load_op[LD_BU]) result = {24'h0, byte_sel};
    else if (load_op[LD_H])  result = {{16{half_sel[15]}}, half_sel};
    else if (load_op[LD_HU]) result = {16'h0, half_sel};
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ------------------------------------------------------------------
// mem_stage : EXE->WB pipeline stage, waits on load responses
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 es_to_ms_valid,
  input  logic [ES_BUS_W-1:0]  es_to_ms_bus,
  output logic                 ms_allowin,
  input  logic                 es_req_cancel,
  input  logic                 ws_allowin,
  output logic                 ms_to_ws_valid,
  output logic [MS_BUS_W-1:0]  ms_to_ws_bus,
  output logic [FWD_BUS_W-1:0] ms_fwd_bus,
  output logic                 ms_ex,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 wb_ex,
  input  logic                 wb_ertn
);

  logic        ms_valid_q, ms_valid_d;
  es_bus_t     bus_q, bus_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;
  logic        rdata_buf_valid_q, rdata_buf_valid_d;
  logic [1:0]  discard_cnt_q, discard_cnt_d;

  logic        flush;
  logic        no_discard;
  logic        data_ok_cur;
  logic        ms_ready_go;
  logic        ms_leave;
  logic        cur_abandoned;
  logic [2:0]  discard_sum;
  logic        ms_load_pending;
  logic [31:0] load_src;
  logic [31:0] load_result;
  logic [31:0] final_result;
  ms_bus_t     ws_bus;

  assign flush       = wb_ex | wb_ertn;
  assign no_discard  = (discard_cnt_q == 2'd0);
  // A response only belongs to the resident instruction once all stale ones are drained
  assign data_ok_cur = data_sram_data_ok & no_discard;

  assign ms_ready_go    = no_discard & (!bus_q.req_issued | data_sram_data_ok | rdata_buf_valid_q);
  assign ms_allowin     = !ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign ms_leave       = ms_to_ws_valid & ws_allowin;

  assign cur_abandoned = ms_valid_q & bus_q.req_issued & !data_ok_cur & !rdata_buf_valid_q;

  always_comb begin
    discard_sum = {1'b0, discard_cnt_q} - {2'b00, data_sram_data_ok & !no_discard};
    if (flush) begin
      discard_sum = discard_sum + {2'b00, cur_abandoned} + {2'b00, es_req_cancel};
    end
    discard_cnt_d = (discard_sum > 3'd2) ? 2'd2 : discard_sum[1:0];
  end

  always_comb begin
    ms_valid_d = ms_valid_q;
    bus_d      = bus_q;
    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    if (es_to_ms_valid && ms_allowin) begin
      bus_d = es_bus_t'(es_to_ms_bus);
    end
    if (flush) begin
      ms_valid_d = 1'b0;
    end
  end

  always_comb begin
    rdata_buf_d       = rdata_buf_q;
    rdata_buf_valid_d = rdata_buf_valid_q;
    if (flush || ms_leave) begin
      rdata_buf_valid_d = 1'b0;
    end else if (data_ok_cur && ms_valid_q && bus_q.req_issued && !ws_allowin) begin
      rdata_buf_d       = data_sram_rdata;
      rdata_buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q        <= 1'b0;
      bus_q             <= '0;
      rdata_buf_q       <= 32'h0;
      rdata_buf_valid_q <= 1'b0;
      discard_cnt_q     <= 2'd0;
    end else begin
      ms_valid_q        <= ms_valid_d;
      bus_q             <= bus_d;
      rdata_buf_q       <= rdata_buf_d;
      rdata_buf_valid_q <= rdata_buf_valid_d;
      discard_cnt_q     <= discard_cnt_d;
    end
  end

  assign load_src = rdata_buf_valid_q ? rdata_buf_q : data_sram_rdata;

  mem_stage_load_extend u_load_extend (
    .load_op  (bus_q.load_op),
    .addr_low (bus_q.addr_low),
    .rdata    (load_src),
    .result   (load_result)
  );

  assign final_result = (|bus_q.load_op) ? load_result : bus_q.alu_result;

  always_comb begin
    ws_bus.exception_op = bus_q.exception_op;
    ws_bus.rj_value     = bus_q.rj_value;
    ws_bus.rkd_value    = bus_q.rkd_value;
    ws_bus.csr_data     = bus_q.csr_data;
    ws_bus.gr_we        = bus_q.gr_we;
    ws_bus.dest         = bus_q.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = bus_q.pc;
  end

  assign ms_to_ws_bus    = ws_bus;
  assign ms_load_pending = ms_valid_q & bus_q.req_issued & !ms_ready_go;
  assign ms_fwd_bus      = {ms_load_pending, ms_valid_q, ms_valid_q & bus_q.gr_we,
                            bus_q.dest, final_result};
  assign ms_ex           = ms_valid_q & ((|bus_q.exception_op) | bus_q.csr_data.ertn);

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ------------------------------------------------------------------
// tb_mem_stage : directed checks for mem_stage
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         es_to_ms_valid;
  logic [179:0] es_to_ms_bus;
  logic         ms_allowin;
  logic         es_req_cancel;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [171:0] ms_to_ws_bus;
  logic [39:0]  ms_fwd_bus;
  logic         ms_ex;
  logic         data_ok;
  logic [31:0]  rdata;
  logic         wb_ex;
  logic         wb_ertn;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [4:0] OP_LDB  = 5'b10000;
  localparam logic [4:0] OP_LDBU = 5'b01000;
  localparam logic [4:0] OP_LDH  = 5'b00100;
  localparam logic [4:0] OP_LDHU = 5'b00010;
  localparam logic [4:0] OP_LDW  = 5'b00001;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .es_req_cancel     (es_req_cancel),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_fwd_bus        (ms_fwd_bus),
    .ms_ex             (ms_ex),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .wb_ex             (wb_ex),
    .wb_ertn           (wb_ertn)
  );

  always #5 clk = ~clk;

  function automatic logic [179:0] mk(input logic req, input logic [4:0] lop,
                                      input logic [1:0] al, input logic [3:0] exc,
                                      input logic ertn, input logic we,
                                      input logic [4:0] dst, input logic [31:0] alu,
                                      input logic [31:0] pc);
    mk = {req, lop, al, exc, 32'hAAAA0001, 32'hBBBB0002, ertn, 33'h0, we, dst, alu, pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; es_req_cancel = 1'b0;
    ws_allowin = 1'b1; data_ok = 1'b0; rdata = 32'h0; wb_ex = 1'b0; wb_ertn = 1'b0;

    #2;
    chk("rst_allowin", 64'(ms_allowin), 64'h1);
    chk("rst_valid",   64'(ms_to_ws_valid), 64'h0);
    chk("rst_ex",      64'(ms_ex), 64'h0);
    chk("rst_fwd",     64'(ms_fwd_bus), 64'h0);
    #10 resetn = 1'b1;

    // ld_b, byte 3, response two cycles after issue
    tick;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, OP_LDB, 2'd3, 4'h0, 1'b0, 1'b1, 5'd3, 32'h10000003, 32'h1c000000);
    #1 chk("ldb_allowin", 64'(ms_allowin), 64'h1);
    tick; es_to_ms_valid = 1'b0; #1;
    chk("ldb_wait_valid", 64'(ms_to_ws_valid), 64'h0);
    chk("ldb_pending", 64'(ms_fwd_bus[39]), 64'h1);
    tick; data_ok = 1'b1; rdata = 32'h80112233; #1;
    chk("ldb_valid", 64'(ms_to_ws_valid), 64'h1);
    chk("ldb_result", 64'(ms_to_ws_bus[63:32]), 64'hFFFFFF80);
    tick; data_ok = 1'b0; #1;
    chk("ldb_drained", 64'(ms_to_ws_valid), 64'h0);

    // ld_hu, response buffered while WB stalls
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, OP_LDHU, 2'd2, 4'h0, 1'b0, 1'b1, 5'd4, 32'h10000002, 32'h1c000004);
    tick; es_to_ms_valid = 1'b0; ws_allowin = 1'b0; data_ok = 1'b1; rdata = 32'hBEEF0000; #1;
    chk("ldhu_valid", 64'(ms_to_ws_valid), 64'h1);
    chk("ldhu_stall_allowin", 64'(ms_allowin), 64'h0);
    tick; data_ok = 1'b0; rdata = 32'h00001111; #1;
    chk("ldhu_buf_valid", 64'(ms_to_ws_valid), 64'h1);
    chk("ldhu_buf_result", 64'(ms_to_ws_bus[63:32]), 64'h0000BEEF);
    tick; ws_allowin = 1'b1; #1;
    chk("ldhu_release_result", 64'(ms_to_ws_bus[63:32]), 64'h0000BEEF);
    chk("ldhu_release_allowin", 64'(ms_allowin), 64'h1);
    tick;
    chk("ldhu_drained", 64'(ms_to_ws_valid), 64'h0);

    // ld_h sign extension, response in first MEM cycle
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, OP_LDH, 2'd0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h10000000, 32'h1c000008);
    tick; es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'h00008001; #1;
    chk("ldh_result", 64'(ms_to_ws_bus[63:32]), 64'hFFFF8001);
    // ld_bu byte 1 directly behind it
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, OP_LDBU, 2'd1, 4'h0, 1'b0, 1'b1, 5'd6, 32'h10000001, 32'h1c00000c);
    tick; es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'h0000F500; #1;
    chk("ldbu_result", 64'(ms_to_ws_bus[63:32]), 64'h000000F5);
    tick; data_ok = 1'b0;

    // flush with a pending load plus a cancelled EXE request: two stale responses
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, OP_LDW, 2'd0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h10000010, 32'h1c000010);
    tick; es_to_ms_valid = 1'b0; #1;
    chk("disc_pending", 64'(ms_fwd_bus[39]), 64'h1);
    wb_ex = 1'b1; es_req_cancel = 1'b1;
    tick; wb_ex = 1'b0; es_req_cancel = 1'b0; #1;
    chk("disc_flushed_valid", 64'(ms_fwd_bus[38]), 64'h0);
    chk("disc_allowin", 64'(ms_allowin), 64'h1);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, OP_LDW, 2'd0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h10000020, 32'h1c000020);
    tick; es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'h11111111; #1;
    chk("disc_first_ignored", 64'(ms_to_ws_valid), 64'h0);
    chk("disc_first_pending", 64'(ms_fwd_bus[39]), 64'h1);
    tick; rdata = 32'h22222222; #1;
    chk("disc_second_ignored", 64'(ms_to_ws_valid), 64'h0);
    tick; rdata = 32'h33333333; #1;
    chk("disc_third_valid", 64'(ms_to_ws_valid), 64'h1);
    chk("disc_third_result", 64'(ms_to_ws_bus[63:32]), 64'h33333333);
    tick; data_ok = 1'b0; #1;
    chk("disc_drained", 64'(ms_to_ws_valid), 64'h0);

    // ale exception passes without waiting
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b0, 5'b0, 2'd1, 4'b0001, 1'b0, 1'b0, 5'd0, 32'h10000001, 32'h1c000030);
    tick; es_to_ms_valid = 1'b0; #1;
    chk("ale_valid", 64'(ms_to_ws_valid), 64'h1);
    chk("ale_ms_ex", 64'(ms_ex), 64'h1);
    chk("ale_exc_field", 64'(ms_to_ws_bus[171:168]), 64'h1);
    // ertn also raises ms_ex
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b0, 5'b0, 2'd0, 4'h0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h1c000034);
    tick; es_to_ms_valid = 1'b0; #1;
    chk("ertn_ms_ex", 64'(ms_ex), 64'h1);
    tick;
    chk("ex_cleared", 64'(ms_ex), 64'h0);

    // non-load add forwarded
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b0, 5'b0, 2'd0, 4'h0, 1'b0, 1'b1, 5'd7, 32'h00001234, 32'h1c000040);
    tick; es_to_ms_valid = 1'b0; #1;
    chk("add_fwd", 64'(ms_fwd_bus), 64'({1'b0, 1'b1, 1'b1, 5'd7, 32'h00001234}));
    chk("add_valid", 64'(ms_to_ws_valid), 64'h1);
    chk("add_pc", 64'(ms_to_ws_bus[31:0]), 64'h1c000040);
    chk("add_dest_we", 64'(ms_to_ws_bus[69:64]), 64'h27);
    tick;

    // asynchronous reset while waiting with one stale response outstanding
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, OP_LDW, 2'd0, 4'h0, 1'b0, 1'b1, 5'd10, 32'h10000050, 32'h1c000050);
    tick; es_to_ms_valid = 1'b0; wb_ertn = 1'b1;
    tick; wb_ertn = 1'b0; es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, OP_LDW, 2'd0, 4'h0, 1'b0, 1'b1, 5'd11, 32'h10000060, 32'h1c000060);
    tick; es_to_ms_valid = 1'b0; #1;
    chk("rstw_pending", 64'(ms_fwd_bus[39:38]), 64'h3);
    #2 resetn = 1'b0;
    #1;
    chk("rstw_valid", 64'(ms_to_ws_valid), 64'h0);
    chk("rstw_fwd", 64'(ms_fwd_bus), 64'h0);
    chk("rstw_ex", 64'(ms_ex), 64'h0);
    #2 resetn = 1'b1;
    tick;
    chk("rstw_allowin", 64'(ms_allowin), 64'h1);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, OP_LDW, 2'd0, 4'h0, 1'b0, 1'b1, 5'd12, 32'h10000070, 32'h1c000070);
    tick; es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'hCAFEF00D; #1;
    chk("rstw_after_valid", 64'(ms_to_ws_valid), 64'h1);
    chk("rstw_after_result", 64'(ms_to_ws_bus[63:32]), 64'hCAFEF00D);
    tick; data_ok = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
